// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external single-port-per-direction RAM with 1-cycle read latency.
// Optional sticky Overflow/Underflow flags are built only when RAM_FIFO_CTRL_ERROR_FLAGS_EN is defined.
module ram_fifo_ctrl #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Push_i,
    input  logic [DATA_WIDTH-1:0]    Data_i,
    input  logic                     Pop_i,
    output logic                     RamWriteEnable_o,
    output logic [ADDRESS_WIDTH-1:0] RamWriteAddress_o,
    output logic [DATA_WIDTH-1:0]    RamData_o,
    output logic                     RamReadEnable_o,
    output logic [ADDRESS_WIDTH-1:0] RamReadAddress_o,
    output logic                     Valid_o,
    output logic                     Empty_o,
    output logic                     Full_o,
    output logic [ADDRESS_WIDTH:0]   Count_o,
    output logic                     Overflow_o,
    output logic                     Underflow_o,
    input  logic                     ClearErrors_i
);

    localparam logic [ADDRESS_WIDTH:0] PTR_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    logic [ADDRESS_WIDTH:0] wr_ptr;
    logic [ADDRESS_WIDTH:0] rd_ptr;
    logic                   push_ok;
    logic                   pop_ok;
    logic                   valid_q;

    // Flags come straight from the pointer registers, so they only change on a clock or reset edge.
    assign Empty_o = (wr_ptr == rd_ptr);
    assign Full_o  = (wr_ptr[ADDRESS_WIDTH-1:0] == rd_ptr[ADDRESS_WIDTH-1:0]) &&
                     (wr_ptr[ADDRESS_WIDTH] != rd_ptr[ADDRESS_WIDTH]);
    assign Count_o = wr_ptr - rd_ptr;

    // Gating with Reset keeps the RAM strobes low for the whole reset interval.
    always_comb begin
        push_ok = Reset & Push_i & ~Full_o;
        pop_ok  = Reset & Pop_i & ~Empty_o;
    end

    assign RamWriteEnable_o  = push_ok;
    assign RamWriteAddress_o = wr_ptr[ADDRESS_WIDTH-1:0];
    assign RamData_o         = Data_i;
    assign RamReadEnable_o   = pop_ok;
    assign RamReadAddress_o  = rd_ptr[ADDRESS_WIDTH-1:0];
    assign Valid_o           = valid_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            valid_q <= pop_ok;
        end
    end

`ifdef RAM_FIFO_CTRL_ERROR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // A new error in the same cycle as a clear wins.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (Push_i && Full_o)     overflow_q  <= 1'b1;
            else if (ClearErrors_i)   overflow_q  <= 1'b0;
            if (Pop_i && Empty_o)     underflow_q <= 1'b1;
            else if (ClearErrors_i)   underflow_q <= 1'b0;
        end
    end

    assign Overflow_o  = overflow_q;
    assign Underflow_o = underflow_q;
`else
    logic unused_clear_errors;
    assign unused_clear_errors = ClearErrors_i;
    assign Overflow_o  = 1'b0;
    assign Underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (ADDRESS_WIDTH=2) with a behavioural RAM attached.
module tb_ram_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;
`ifdef RAM_FIFO_CTRL_ERROR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Push_i;
    logic [DW-1:0] Data_i;
    logic          Pop_i;
    logic          ClearErrors_i;
    logic          RamWriteEnable_o;
    logic [AW-1:0] RamWriteAddress_o;
    logic [DW-1:0] RamData_o;
    logic          RamReadEnable_o;
    logic [AW-1:0] RamReadAddress_o;
    logic          Valid_o;
    logic          Empty_o;
    logic          Full_o;
    logic [AW:0]   Count_o;
    logic          Overflow_o;
    logic          Underflow_o;

    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_rdata;

    int checks = 0;
    int failures = 0;

    ram_fifo_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .Push_i            (Push_i),
        .Data_i            (Data_i),
        .Pop_i             (Pop_i),
        .RamWriteEnable_o  (RamWriteEnable_o),
        .RamWriteAddress_o (RamWriteAddress_o),
        .RamData_o         (RamData_o),
        .RamReadEnable_o   (RamReadEnable_o),
        .RamReadAddress_o  (RamReadAddress_o),
        .Valid_o           (Valid_o),
        .Empty_o           (Empty_o),
        .Full_o            (Full_o),
        .Count_o           (Count_o),
        .Overflow_o        (Overflow_o),
        .Underflow_o       (Underflow_o),
        .ClearErrors_i     (ClearErrors_i)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (RamWriteEnable_o) ram_mem[RamWriteAddress_o] <= RamData_o;
        if (RamReadEnable_o)  ram_rdata <= ram_mem[RamReadAddress_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic p, input logic [DW-1:0] d, input logic q, input logic c);
        Push_i        = p;
        Data_i        = d;
        Pop_i         = q;
        ClearErrors_i = c;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [DW-1:0] pushed [4];
        logic [DW-1:0] model_q [$];
        logic [DW-1:0] exp_d;

        pushed[0] = 8'h11; pushed[1] = 8'h22; pushed[2] = 8'h33; pushed[3] = 8'h44;

        // Reset state, with requests held high to prove the strobes stay off.
        Reset = 1'b0;
        set_in(1'b1, 8'hFF, 1'b1, 1'b0);
        #3;
        chk("rst_empty", Empty_o, 1);
        chk("rst_full", Full_o, 0);
        chk("rst_count", Count_o, 0);
        chk("rst_valid", Valid_o, 0);
        chk("rst_we", RamWriteEnable_o, 0);
        chk("rst_re", RamReadEnable_o, 0);
        chk("rst_ovf", Overflow_o, 0);
        chk("rst_unf", Underflow_o, 0);
        repeat (2) tick();
        Reset = 1'b1;
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        // Fill with four words.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, pushed[i], 1'b0, 1'b0);
            #1;
            chk("fill_we", RamWriteEnable_o, 1);
            chk("fill_waddr", RamWriteAddress_o, i);
            chk("fill_wdata", RamData_o, pushed[i]);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fill_full", Full_o, 1);
        chk("fill_count", Count_o, 4);
        chk("fill_empty", Empty_o, 0);

        // Push while full, then set-vs-clear priority, then clear alone.
        set_in(1'b1, 8'h55, 1'b0, 1'b0);
        #1;
        chk("ovf_we", RamWriteEnable_o, 0);
        tick();
        chk("ovf_count", Count_o, 4);
        chk("ovf_flag", Overflow_o, ERR_EN);
        set_in(1'b1, 8'h66, 1'b0, 1'b1);
        tick();
        chk("ovf_set_prio", Overflow_o, ERR_EN);
        set_in(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        chk("ovf_clear", Overflow_o, 0);

        // Drain back-to-back; data arrives the cycle after each pop.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            chk("drain_re", RamReadEnable_o, 1);
            chk("drain_raddr", RamReadAddress_o, i);
            tick();
            chk("drain_valid", Valid_o, 1);
            chk("drain_data", ram_rdata, pushed[i]);
        end
        chk("drain_empty", Empty_o, 1);
        chk("drain_count", Count_o, 0);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("drain_valid_off", Valid_o, 0);

        // Empty with push and pop together: push wins, pop is an underflow.
        set_in(1'b1, 8'hA5, 1'b1, 1'b0);
        #1;
        chk("emp_we", RamWriteEnable_o, 1);
        chk("emp_re", RamReadEnable_o, 0);
        chk("emp_waddr", RamWriteAddress_o, 0);
        tick();
        chk("emp_count", Count_o, 1);
        chk("emp_unf", Underflow_o, ERR_EN);
        chk("emp_valid", Valid_o, 0);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        chk("emp_raddr", RamReadAddress_o, 0);
        tick();
        chk("emp_valid2", Valid_o, 1);
        chk("emp_data", ram_rdata, 8'hA5);
        chk("emp_empty", Empty_o, 1);
        set_in(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        chk("unf_clear", Underflow_o, 0);

        // Prime two words, then six simultaneous push/pop pairs across the wrap.
        set_in(1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        model_q.push_back(8'h01);
        set_in(1'b1, 8'h02, 1'b0, 1'b0);
        tick();
        model_q.push_back(8'h02);
        chk("wrap_count0", Count_o, 2);
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
            #1;
            chk("wrap_waddr", RamWriteAddress_o, (3 + i) % 4);
            chk("wrap_raddr", RamReadAddress_o, (1 + i) % 4);
            tick();
            model_q.push_back(8'h10 + 8'(i));
            exp_d = model_q.pop_front();
            chk("wrap_count", Count_o, 2);
            chk("wrap_valid", Valid_o, 1);
            chk("wrap_data", ram_rdata, exp_d);
        end

        // Bring to three words, pop once, and reset while that read is still valid.
        set_in(1'b1, 8'h16, 1'b0, 1'b0);
        tick();
        chk("mid_count", Count_o, 3);
        set_in(1'b1, 8'h00, 1'b1, 1'b0);
        tick();
        chk("mid_valid", Valid_o, 1);
        #1;
        Reset = 1'b0;
        #1;
        chk("mid_rst_valid", Valid_o, 0);
        chk("mid_rst_count", Count_o, 0);
        chk("mid_rst_empty", Empty_o, 1);
        chk("mid_rst_full", Full_o, 0);
        chk("mid_rst_we", RamWriteEnable_o, 0);
        chk("mid_rst_re", RamReadEnable_o, 0);
        chk("mid_rst_ovf", Overflow_o, 0);
        chk("mid_rst_unf", Underflow_o, 0);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        tick();
        chk("post_empty", Empty_o, 1);
        chk("post_count", Count_o, 0);
        chk("post_valid", Valid_o, 0);
        set_in(1'b1, 8'h77, 1'b0, 1'b0);
        #1;
        chk("post_waddr", RamWriteAddress_o, 0);
        tick();
        chk("post_count1", Count_o, 1);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, meaning RAM address width; capacity = 2**ADDRESS_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning word width.
REQ-003 SHALL have port Clock  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Push_i  input  1  write request.
REQ-006 SHALL have port Data_i  input  DATA_WIDTH  write data.
REQ-007 SHALL have port Pop_i  input  1  read request.
REQ-008 SHALL have port RamWriteEnable_o  output  1  RAM write enable.
REQ-009 SHALL have port RamWriteAddress_o  output  ADDRESS_WIDTH  RAM write address.
REQ-010 SHALL have port RamData_o  output  DATA_WIDTH  RAM write data (equals Data_i).
REQ-011 SHALL have port RamReadEnable_o  output  1  RAM read enable.
REQ-012 SHALL have port RamReadAddress_o  output  ADDRESS_WIDTH  RAM read address.
REQ-013 SHALL have port Valid_o  output  1  RAM read data valid this cycle.
REQ-014 SHALL have port Empty_o, Full_o  output  1 each  occupancy flags.
REQ-015 SHALL have port Count_o  output  ADDRESS_WIDTH+1  stored word count.
REQ-016 SHALL have port Overflow_o, Underflow_o  output  1 each  sticky error flags.
REQ-017 SHALL have port ClearErrors_i  input  1  clears sticky flags.

Function
REQ-018 SHALL keep write and read pointers of ADDRESS_WIDTH+1 bits; RAM addresses = low ADDRESS_WIDTH bits; pointers wrap modulo 2**(ADDRESS_WIDTH+1).
REQ-019 SHALL assert Empty_o when pointers are equal; Full_o when low bits equal and MSBs differ; both registered-state derived, glitch-free.
REQ-020 SHALL accept push iff Push_i=1 and Full_o=0; accepted push drives RamWriteEnable_o=1 combinationally in same cycle, address = write pointer, then increments write pointer.
REQ-021 SHALL accept pop iff Pop_i=1 and Empty_o=0; accepted pop drives RamReadEnable_o=1 combinationally, address = read pointer, then increments read pointer.
REQ-022 SHALL assert Valid_o for exactly one cycle, the cycle after each accepted pop (RAM read latency 1).
REQ-023 SHALL update Count_o: +1 push only, -1 pop only, unchanged when both or neither accepted.
REQ-024 SHALL, when full with Push_i and Pop_i both high, accept the pop and reject the push.
REQ-025 SHALL, when empty with Push_i and Pop_i both high, accept the push and reject the pop (no read-before-write on same address).
REQ-026 SHALL set Overflow_o on rejected push, Underflow_o on rejected pop; held until ClearErrors_i or reset; set has priority over clear in the same cycle.

Reset
REQ-027 SHALL on Reset=0, immediately: pointers 0, Count_o 0, Empty_o 1, Full_o 0, Valid_o 0, Overflow_o 0, Underflow_o 0.
REQ-028 SHALL force RamWriteEnable_o and RamReadEnable_o to 0 while Reset=0; RAM contents not cleared.
REQ-029 SHALL, on reset mid-operation, discard pending Valid_o and restart empty on first clock after release.

Configuration
REQ-030 SHALL compile sticky error flags only when macro RAM_FIFO_CTRL_ERROR_FLAGS_EN is defined; without it Overflow_o and Underflow_o are constant 0, ClearErrors_i is ignored, all other behaviour unchanged.

Verification (ADDRESS_WIDTH=2, DATA_WIDTH=8, RAM model attached)
REQ-031 SHALL cover: reset then 4 pushes 0x11,0x22,0x33,0x44 -> Full_o=1, Count_o=4, write addresses 0,1,2,3.
REQ-032 SHALL cover: 5th push 0x55 when full -> RamWriteEnable_o=0, Count_o stays 4, Overflow_o=1 (macro defined).
REQ-033 SHALL cover: 4 pops after fill -> Valid_o one cycle after each, RAM data 0x11,0x22,0x33,0x44 in order, Empty_o=1.
REQ-034 SHALL cover: pop when empty with simultaneous push 0xA5 -> Underflow_o=1, Count_o=1, next pop returns 0xA5.
REQ-035 SHALL cover: 6 push/pop pairs from Count_o=2 -> pointers wrap, Count_o stays 2, data order preserved.
REQ-036 SHALL cover: Reset asserted mid-stream at Count_o=3 -> all outputs at reset values without clock edge; with macro undefined Overflow_o stays 0 under REQ-032 stimulus.
